// File: rtl/player_ctrl.sv
// Player controller: per-frame movement with wall and screen-edge rejection,
// blast damage with a post-hit immunity window, and edge-triggered bomb drop.
module player_ctrl #(
  parameter int N_WALLS = 4,
  parameter int N_BOMBS = 2,
  parameter int SIZE    = 8,
  parameter int STEP    = 1,
  parameter int START_X = 619,
  parameter int START_Y = 459,
  parameter int LIVES   = 3,
  parameter int INVULN  = 60,
  parameter logic [7:0] KEY_UP   = 8'h52,
  parameter logic [7:0] KEY_DN   = 8'h51,
  parameter logic [7:0] KEY_LT   = 8'h50,
  parameter logic [7:0] KEY_RT   = 8'h4F,
  parameter logic [7:0] KEY_BOMB = 8'h13
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [7:0]              keycode,
  input  logic [10*N_WALLS-1:0]   wallX,
  input  logic [10*N_WALLS-1:0]   wallY,
  input  logic [10*N_WALLS-1:0]   wallS,
  input  logic [10*N_BOMBS-1:0]   bombX,
  input  logic [10*N_BOMBS-1:0]   bombY,
  input  logic [10*N_BOMBS-1:0]   bombS,
  input  logic [N_BOMBS-1:0]      bomb_live,
  input  logic [N_BOMBS-1:0]      bomb_blast,
  output logic [9:0]              userX,
  output logic [9:0]              userY,
  output logic [9:0]              userS,
  output logic [2:0]              heart,
  output logic                    damage,
  output logic                    collide,
  output logic                    bomb_drop,
  output logic                    dead
);

  typedef enum logic [1:0] {ST_ALIVE, ST_INVULN, ST_DEAD} state_t;

  // All box arithmetic is done at 11 bits so coordinate sums never wrap.
  localparam logic [10:0] SIZE_W = 11'(SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] X_LIM  = 11'd640;
  localparam logic [10:0] Y_LIM  = 11'd480;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [2:0]  heart_q, heart_d;
  logic        damage_q, damage_d;
  logic        collide_q, collide_d;
  logic        drop_q, drop_d;
  logic        bomb_prev_q, bomb_prev_d;

  logic [10:0] cand_x, cand_y;
  logic        cand_ok;
  logic [N_WALLS-1:0] wall_hit;
  logic [N_BOMBS-1:0] blast_hit;
  logic        move_ok;
  logic        bomb_press;

  function automatic logic box_overlap(input logic [10:0] ax, input logic [10:0] ay,
                                       input logic [10:0] bx, input logic [10:0] by,
                                       input logic [10:0] bs);
    return (ax < bx + bs) && (bx < ax + SIZE_W) && (ay < by + bs) && (by < ay + SIZE_W);
  endfunction

  // Candidate position for this frame's key; underflow and screen-edge overrun reject it.
  always_comb begin
    cand_x  = {1'b0, x_q};
    cand_y  = {1'b0, y_q};
    cand_ok = 1'b1;
    case (keycode)
      KEY_UP: begin
        if ({1'b0, y_q} < STEP_W) cand_ok = 1'b0;
        else                      cand_y  = {1'b0, y_q} - STEP_W;
      end
      KEY_DN: cand_y = {1'b0, y_q} + STEP_W;
      KEY_LT: begin
        if ({1'b0, x_q} < STEP_W) cand_ok = 1'b0;
        else                      cand_x  = {1'b0, x_q} - STEP_W;
      end
      KEY_RT: cand_x = {1'b0, x_q} + STEP_W;
      default: ;
    endcase
    if ((cand_x + SIZE_W > X_LIM) || (cand_y + SIZE_W > Y_LIM)) cand_ok = 1'b0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_WALLS; gi++) begin : g_wall
      assign wall_hit[gi] = box_overlap(cand_x, cand_y,
                                        {1'b0, wallX[10*gi +: 10]},
                                        {1'b0, wallY[10*gi +: 10]},
                                        {1'b0, wallS[10*gi +: 10]});
    end
    // Blast overlap uses the current (registered) position, not the candidate.
    for (gi = 0; gi < N_BOMBS; gi++) begin : g_bomb
      assign blast_hit[gi] = bomb_blast[gi] &&
                             box_overlap({1'b0, x_q}, {1'b0, y_q},
                                         {1'b0, bombX[10*gi +: 10]},
                                         {1'b0, bombY[10*gi +: 10]},
                                         {1'b0, bombS[10*gi +: 10]});
    end
  endgenerate

  assign move_ok    = cand_ok && !(|wall_hit);
  assign bomb_press = (keycode == KEY_BOMB) && !bomb_prev_q;

  // Next-state logic: movement, hit/immunity handling and bomb drop request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    heart_d     = heart_q;
    damage_d    = 1'b0;
    drop_d      = 1'b0;
    collide_d   = |blast_hit;
    bomb_prev_d = (keycode == KEY_BOMB);

    if (state_q != ST_DEAD && move_ok) begin
      x_d = cand_x[9:0];
      y_d = cand_y[9:0];
    end

    case (state_q)
      ST_ALIVE: begin
        if (|blast_hit) begin
          heart_d  = heart_q - 3'd1;
          damage_d = 1'b1;
          if (heart_q <= 3'd1) begin
            state_d = ST_DEAD;
          end else if (INVULN > 0) begin
            state_d = ST_INVULN;
            cnt_d   = 16'(INVULN);
          end
        end
      end
      ST_INVULN: begin
        // Immune while the counter runs; the frame it would reach zero returns to ALIVE.
        if (cnt_q <= 16'd1) begin
          state_d = ST_ALIVE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DEAD: ;
      default: state_d = ST_ALIVE;
    endcase

    // A drop needs a free slot and a living player after this edge's hit.
    if (bomb_press && !(&bomb_live) && state_d != ST_DEAD) drop_d = 1'b1;
  end

  // State and output registers with synchronous reset to the spawn condition.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= ST_ALIVE;
      cnt_q       <= 16'd0;
      x_q         <= 10'(START_X);
      y_q         <= 10'(START_Y);
      heart_q     <= 3'(LIVES);
      damage_q    <= 1'b0;
      collide_q   <= 1'b0;
      drop_q      <= 1'b0;
      bomb_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      heart_q     <= heart_d;
      damage_q    <= damage_d;
      collide_q   <= collide_d;
      drop_q      <= drop_d;
      bomb_prev_q <= bomb_prev_d;
    end
  end

  assign userX     = x_q;
  assign userY     = y_q;
  assign userS     = 10'(SIZE);
  assign heart     = heart_q;
  assign damage    = damage_q;
  assign collide   = collide_q;
  assign bomb_drop = drop_q;
  assign dead      = (state_q == ST_DEAD);

endmodule

// File: tb/tb_player_ctrl.sv
// Testbench for player_ctrl: directed scenarios followed by randomized frames,
// all compared every frame against a behavioural model of the player.
module tb_player_ctrl;
  localparam int NW = 4;
  localparam int NB = 2;
  localparam int SIZE = 8;
  localparam int STEP = 1;
  localparam int SX = 619;
  localparam int SY = 459;
  localparam int LIVES = 3;
  localparam int INV = 60;
  localparam logic [7:0] K_UP = 8'h52;
  localparam logic [7:0] K_DN = 8'h51;
  localparam logic [7:0] K_LT = 8'h50;
  localparam logic [7:0] K_RT = 8'h4F;
  localparam logic [7:0] K_BOMB = 8'h13;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] key;
  logic [10*NW-1:0] wallX, wallY, wallS;
  logic [10*NB-1:0] bombX, bombY, bombS;
  logic [NB-1:0] live, blast;
  logic [9:0] userX, userY, userS;
  logic [2:0] heart;
  logic damage, collide, bomb_drop, dead;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int mx, my, mheart, immune_until, frame;
  bit mdead, mprev, mdamage, mcollide, mdrop;
  int drops_seen;
  int saved_y;

  player_ctrl #(
    .N_WALLS(NW), .N_BOMBS(NB), .SIZE(SIZE), .STEP(STEP),
    .START_X(SX), .START_Y(SY), .LIVES(LIVES), .INVULN(INV),
    .KEY_UP(K_UP), .KEY_DN(K_DN), .KEY_LT(K_LT), .KEY_RT(K_RT), .KEY_BOMB(K_BOMB)
  ) dut (
    .frame_clk(clk), .Reset(rst), .keycode(key),
    .wallX(wallX), .wallY(wallY), .wallS(wallS),
    .bombX(bombX), .bombY(bombY), .bombS(bombS),
    .bomb_live(live), .bomb_blast(blast),
    .userX(userX), .userY(userY), .userS(userS),
    .heart(heart), .damage(damage), .collide(collide),
    .bomb_drop(bomb_drop), .dead(dead)
  );

  always #5 clk = ~clk;

  function automatic bit ovl(int ax, int ay, int bx, int by, int bs);
    return (ax < bx + bs) && (bx < ax + SIZE) && (ay < by + bs) && (by < ay + SIZE);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one frame using the inputs currently applied.
  task automatic model_step();
    bit hit_now, press, ok;
    int nx, ny;
    if (rst) begin
      mx = SX; my = SY; mheart = LIVES; mdead = 0; mprev = 0;
      mdamage = 0; mcollide = 0; mdrop = 0; immune_until = frame;
      frame++;
      return;
    end
    hit_now = 0;
    for (int i = 0; i < NB; i++)
      if (blast[i] && ovl(mx, my, int'(bombX[10*i +: 10]), int'(bombY[10*i +: 10]),
                          int'(bombS[10*i +: 10])))
        hit_now = 1;
    mcollide = hit_now;
    mdamage = 0;
    mdrop = 0;
    press = (key == K_BOMB) && !mprev;
    mprev = (key == K_BOMB);
    if (!mdead) begin
      nx = mx; ny = my;
      if (key == K_UP) ny = my - STEP;
      else if (key == K_DN) ny = my + STEP;
      else if (key == K_LT) nx = mx - STEP;
      else if (key == K_RT) nx = mx + STEP;
      ok = (nx >= 0) && (ny >= 0) && (nx + SIZE <= 640) && (ny + SIZE <= 480);
      for (int i = 0; i < NW; i++)
        if (ovl(nx, ny, int'(wallX[10*i +: 10]), int'(wallY[10*i +: 10]), int'(wallS[10*i +: 10])))
          ok = 0;
      if (ok) begin mx = nx; my = ny; end
      if (hit_now && frame > immune_until) begin
        mheart--;
        mdamage = 1;
        if (mheart == 0) mdead = 1;
        else immune_until = frame + INV;
      end
      if (press && live != {NB{1'b1}} && !mdead) mdrop = 1;
    end
    frame++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (bomb_drop === 1'b1) drops_seen++;
    check("userX", userX, mx);
    check("userY", userY, my);
    check("userS", userS, SIZE);
    check("heart", heart, mheart);
    check("damage", damage, mdamage);
    check("collide", collide, mcollide);
    check("bomb_drop", bomb_drop, mdrop);
    check("dead", dead, mdead);
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  function automatic logic [7:0] pick_key();
    logic [7:0] k;
    case ($urandom_range(0, 5))
      0: k = K_UP;
      1: k = K_DN;
      2: k = K_LT;
      3: k = K_RT;
      4: k = K_BOMB;
      default: k = 8'($urandom_range(0, 255));
    endcase
    return k;
  endfunction

  function automatic logic [9:0] clamp10(int v);
    if (v < 0) return 10'd0;
    if (v > 1023) return 10'd1023;
    return 10'(v);
  endfunction

  initial begin
    frame = 0; immune_until = 0; drops_seen = 0;
    rst = 1; key = 8'h00;
    wallX = '0; wallY = '0; wallS = '0;   // zero-size walls at origin never overlap
    bombX = '0; bombY = '0; bombS = '0;
    live = '0; blast = '0;

    // Reset state
    do_reset();
    check("reset_x", userX, 619);
    check("reset_heart", heart, 3);

    // Hold left 5 frames, then release
    key = K_LT; repeat (5) tick();
    check("left5_x", userX, 614);
    key = 8'h00; repeat (3) tick();
    check("release_x", userX, 614);
    check("release_y", userY, 459);

    // Wall at (600,459,8) blocks leftward motion at 608
    wallX[9:0] = 10'd600; wallY[9:0] = 10'd459; wallS[9:0] = 10'd8;
    key = K_LT; repeat (15) tick();
    check("wall_stop_x", userX, 608);
    key = 8'h00; wallS = '0; wallX = '0; wallY = '0;

    // Held bomb key: one pulse; all slots live: none
    live = 2'b00; drops_seen = 0; key = K_BOMB; repeat (20) tick();
    check("held_bomb_pulses", drops_seen, 1);
    key = 8'h00; tick();
    live = 2'b11; drops_seen = 0; key = K_BOMB; repeat (3) tick();
    check("full_bomb_pulses", drops_seen, 0);
    key = 8'h00; live = 2'b00; tick();

    // Blast over player: hit, immunity, then second hit
    bombX[9:0] = clamp10(mx - 2); bombY[9:0] = clamp10(my - 2); bombS[9:0] = 10'd12;
    blast = 2'b01; tick();
    check("first_hit_heart", heart, 2);
    check("first_hit_damage", damage, 1);
    repeat (INV) tick();
    check("immune_heart", heart, 2);
    tick();
    check("second_hit_heart", heart, 1);
    blast = 2'b00; repeat (5) tick();

    // Three separated hits kill; dead player frozen; reset revives
    do_reset();
    bombX[9:0] = clamp10(mx - 2); bombY[9:0] = clamp10(my - 2);
    for (int k = 0; k < 3; k++) begin
      blast = 2'b01; tick();
      blast = 2'b00; repeat (INV + 2) tick();
    end
    check("dead_flag", dead, 1);
    check("dead_heart", heart, 0);
    saved_y = my;
    key = K_UP; repeat (5) tick();
    check("dead_no_move", userY, saved_y);
    drops_seen = 0; key = K_BOMB; repeat (5) tick();
    check("dead_no_drop", drops_seen, 0);
    key = 8'h00;
    do_reset();
    check("revive_heart", heart, 3);
    check("revive_dead", dead, 0);

    // Screen edges: left to X=0, down to Y=472
    key = K_LT; repeat (630) tick();
    check("left_edge_x", userX, 0);
    key = K_DN; repeat (20) tick();
    check("bottom_edge_y", userY, 472);
    key = 8'h00; tick();

    // Randomized frames
    for (int f = 0; f < 3000; f++) begin
      if ($urandom_range(0, 3) == 0) key = pick_key();
      if (f % 40 == 0) begin
        for (int i = 0; i < NW; i++) begin
          wallX[10*i +: 10] = clamp10(mx + int'($urandom_range(0, 60)) - 30);
          wallY[10*i +: 10] = clamp10(my + int'($urandom_range(0, 60)) - 30);
          wallS[10*i +: 10] = 10'($urandom_range(0, 20));
        end
        for (int i = 0; i < NB; i++) begin
          bombX[10*i +: 10] = clamp10(mx + int'($urandom_range(0, 30)) - 15);
          bombY[10*i +: 10] = clamp10(my + int'($urandom_range(0, 30)) - 15);
          bombS[10*i +: 10] = 10'($urandom_range(4, 24));
        end
      end
      if (f % 10 == 0) live = NB'($urandom_range(0, (1 << NB) - 1));
      for (int i = 0; i < NB; i++) blast[i] = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/player_ctrl.md
PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 SHALL expose parameter N_WALLS, default 4, number of wall boxes checked.
REQ-002 SHALL expose parameter N_BOMBS, default 2, number of bomb slots.
REQ-003 SHALL expose parameter SIZE, default 8, player box edge in pixels.
REQ-004 SHALL expose parameter STEP, default 1, pixels moved per frame.
REQ-005 SHALL expose parameter START_X, default 619, reset/spawn X.
REQ-006 SHALL expose parameter START_Y, default 459, reset/spawn Y.
REQ-007 SHALL expose parameter LIVES, default 3, initial hearts (1..7).
REQ-008 SHALL expose parameter INVULN, default 60, frames of immunity after a hit.
REQ-009 SHALL expose parameters KEY_UP/KEY_DN/KEY_LT/KEY_RT/KEY_BOMB, defaults 8'h52/8'h51/8'h50/8'h4F/8'h13, keycodes.
REQ-010 frame_clk  in  1  sole clock; all state updates on its rising edge.
REQ-011 Reset  in  1  synchronous, active-high reset.
REQ-012 keycode  in  8  current key; one action per frame.
REQ-013 wallX, wallY, wallS  in  10*N_WALLS each  packed wall boxes, slot i at bits [10i+9:10i].
REQ-014 bombX, bombY, bombS  in  10*N_BOMBS each  packed bomb boxes.
REQ-015 bomb_live  in  N_BOMBS  slot occupied; bomb_blast  in  N_BOMBS  slot currently exploding.
REQ-016 userX, userY, userS  out  10 each  player top-left position and size.
REQ-017 heart  out  3  remaining lives; damage  out  1  one-frame hit pulse; collide  out  1  blast overlap level; bomb_drop  out  1  one-frame drop request; dead  out  1  player eliminated.

Function
REQ-018 Box overlap SHALL be defined as ax < bx+bs && bx < ax+SIZE on both axes, computed at 11 bits, no wrap.
REQ-019 In ALIVE/INVULN, keycode KEY_UP/DN/LT/RT SHALL form candidate position pos-/+STEP on Y or X; other keys leave position unchanged; motion SHALL NOT persist after key release.
REQ-020 Candidate SHALL be rejected (position held, no teleport) if it leaves [0,639]x[0,479] (X+SIZE > 640, Y+SIZE > 480, or underflow below 0) or overlaps any wall slot.
REQ-021 Accepted candidate SHALL become userX/userY on the next frame_clk edge (latency 1).
REQ-022 collide SHALL be registered: 1 the frame after the current position overlaps any slot with bomb_blast=1, in any state.
REQ-023 State machine SHALL be ALIVE, INVULN, DEAD; reset enters ALIVE.
REQ-024 ALIVE + blast overlap: heart decrements by 1, damage pulses 1 frame; next state INVULN with counter=INVULN, or DEAD if heart becomes 0.
REQ-025 INVULN: blasts ignored (no decrement, no damage); counter decrements each frame; at 0 returns to ALIVE; movement still allowed.
REQ-026 DEAD: dead=1, position, heart frozen, no movement, no bomb_drop; only Reset exits.
REQ-027 bomb_drop SHALL pulse exactly 1 frame on the rising edge of keycode==KEY_BOMB (previous frame != KEY_BOMB), only if some bomb_live bit is 0 and state is not DEAD; holding the key SHALL NOT re-trigger.
REQ-028 Drop request with all bomb_live=1 SHALL be discarded, not queued.
REQ-029 Simultaneous hit and move: move evaluated from old position and applied; hit applied same edge.
REQ-030 Simultaneous hit reaching heart=0 and drop edge: drop suppressed.

Reset
REQ-031 Reset=1 on a frame_clk edge SHALL set userX=START_X, userY=START_Y, heart=LIVES, state ALIVE, counter 0, damage=0, collide=0, bomb_drop=0, dead=0, key history cleared, regardless of state mid-operation.
REQ-032 userS SHALL equal SIZE at all times.

Verification
REQ-033 Reset, then hold KEY_LT 5 frames, STEP=1 -> userX 619->614, userY 459; release -> position holds.
REQ-034 Wall at (600,459,s=8), hold KEY_LT from X=619 -> X stops at 608 and holds; no respawn.
REQ-035 bomb_blast[0] box covering player, LIVES=3 -> heart 2, damage one frame; blast held 10 frames, INVULN=60 -> heart stays 2; after 60 frames with blast still on -> heart 1.
REQ-036 Three separated hits -> heart 0, dead=1; then KEY_UP and KEY_BOMB -> no movement, bomb_drop stays 0; Reset -> heart 3, dead 0.
REQ-037 KEY_BOMB held 20 frames, bomb_live=2'b00 -> exactly one bomb_drop pulse; bomb_live=2'b11 and fresh press -> no pulse.
REQ-038 Player at X=0, hold KEY_LT; player at Y=472, hold KEY_DN -> positions hold at 0 and 472.
